complement_display_ctrl: RTL and testbench
==========================================

// Module: complement_display_ctrl
// PURPOSE
//  Parametrised, clocked successor to the switch->complement->7-seg path on the DE1-SoC.
//  Samples an IN_W-bit switch value and shows it on N_DIGITS active-low 7-seg displays.
//  The display mode is RAW, ones' complement, two's complement or signed magnitude.
//  Debounced KEY presses cycle the mode and freeze/unfreeze the sampled value.
// PARAMETERS
//  IN_W            10      switch input width; 4*(N_DIGITS-1) >= IN_W required
//  N_DIGITS        4       number of hex digits driven; result width W = 4*N_DIGITS
//  DEBOUNCE_CYCLES 500000  stable cycles before a key level is accepted (10 ms @ 50 MHz), >= 2
// PORTS
//  CLOCK_50  in   1             system clock, rising edge
//  RESET_N   in   1             asynchronous, active-low reset
//  SW        in   IN_W          switch value, asynchronous to CLOCK_50
//  KEY       in   2             active-low pushbuttons; KEY[0]=next mode, KEY[1]=freeze toggle
//  HEX       out  7*N_DIGITS    segments, active-low; digit i on HEX[7*i+6:7*i], digit 0 = LSD
//  MODE      out  2             current mode: 0 RAW, 1 C1, 2 C2, 3 SMAG
//  FROZEN    out  1             1 = displayed value held, SW ignored
// BEHAVIOUR
//  Reset (async assert, sync release via CLOCK_50 edge):
//   MODE=0, FROZEN=0, val_q=0, res_q=0, every HEX digit=7'h7F (blank).
//   Debouncers: accepted level=1 (released), counters=0.
//  Key path, per key, independent:
//   2-FF synchroniser, then counter.
//   Counter clears whenever the synced level equals the accepted level.
//   Otherwise it increments; at DEBOUNCE_CYCLES-1 the accepted level flips and the counter clears.
//   A press event is a one-cycle pulse on an accepted 1->0 flip; releases generate nothing.
//   Glitches shorter than DEBOUNCE_CYCLES produce no event; a held key produces exactly one event.
//  Events:
//   KEY[0] event: MODE <= MODE+1, wrapping 3->0.
//   KEY[1] event: FROZEN <= ~FROZEN.
//   Both in the same cycle: both take effect.
//  Datapath:
//   val_q <= SW every cycle while FROZEN=0; holds while FROZEN=1.
//   The freeze event cycle itself still samples.
//   res_q (W bits) <= f(val_q, MODE) every cycle; a MODE change applies even while frozen.
//   ext = zero-extend val_q to W.
//   RAW: ext.
//   C1: ~ext (W bits).
//   C2: (~ext + 1) mod 2^W; 0 -> 0.
//   SMAG: val_q is IN_W-bit two's complement.
//    Magnitude goes in the low N_DIGITS-1 digits.
//    Top digit is '-' (7'b0111111) when negative, blank (7'h7F) otherwise.
//    The most negative value shows magnitude 2^(IN_W-1).
//  Segment encode:
//   HEX <= decode(res_q), registered, standard DE1-SoC active-low hex glyphs 0-F.
//   The SMAG sign digit overrides the glyph.
//  Latency:
//   SW sampled at edge k appears on HEX after edge k+2.
//   A key event at edge k reaches MODE/FROZEN at edge k; HEX reflects it after edge k+2.
//  Reset mid-debounce or mid-press:
//   All state returns to reset values.
//   A key still held at release must be released and re-debounced before it produces an event.
//  No other outputs; no handshake; HEX is always driven.
// TESTING (DEBOUNCE_CYCLES=4, defaults otherwise)
//  1. Reset then SW=10'h005, no keys.
//     -> HEX digits 3..0 = "0005" after 2 clocks; MODE=0; FROZEN=0.
//  2. SW=10'h005; press KEY[0] once (held 10 cycles).
//     -> MODE=1, HEX="FFFA".
//     Press again -> MODE=2, HEX="FFFB".
//  3. MODE=3.
//     SW=10'h3FF -> "-001".
//     SW=10'h200 -> "-200".
//     SW=10'h1FF -> blank,"1FF".
//     SW=0 -> blank,"000".
//  4. SW=10'h123; press KEY[1] -> FROZEN=1.
//     Change SW to 10'h3C0 -> HEX stays "0123".
//     Switch to C1 -> "FEDC".
//     Press KEY[1] again -> "FC3F".
//  5. Bounce KEY[0] low for 2 cycles, 3 times -> no MODE change.
//     Hold low 4+ cycles -> exactly one increment.
//     From MODE=3 -> wraps to 0.
//  6. Assert RESET_N low mid-debounce with KEY[0] held.
//     -> HEX all 7'h7F, MODE=0, FROZEN=0 immediately.
//     No event fires after release while the key remains held.

Source files
------------

// File: rtl/complement_display_ctrl.sv
// Switch value -> RAW / ones' / two's complement / signed-magnitude on active-low 7-seg digits.
// Two debounced keys step the display mode and freeze/unfreeze the sampled switch value.
module complement_display_ctrl #(
    parameter int unsigned IN_W            = 10,
    parameter int unsigned N_DIGITS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [IN_W-1:0]       SW,
    input  logic [1:0]            KEY,
    output logic [7*N_DIGITS-1:0] HEX,
    output logic [1:0]            MODE,
    output logic                  FROZEN
);

    localparam int unsigned W     = 4 * N_DIGITS;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ModeRaw  = 2'd0,
        ModeC1   = 2'd1,
        ModeC2   = 2'd2,
        ModeSmag = 2'd3
    } mode_e;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Key path state
    logic [1:0]       key_s1_q, key_s2_q;
    logic [1:0]       acc_q, acc_d;
    logic [1:0]       arm_q, arm_d;
    logic [1:0]       vld_q;
    logic [1:0]       press;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    // Control and datapath state
    mode_e            mode_q, mode_d;
    logic             frozen_q, frozen_d;
    logic [IN_W-1:0]  val_q, val_d;
    logic [W-1:0]     res_q, res_d;
    logic             smag_q, smag_d;
    logic             neg_q, neg_d;
    logic [7*N_DIGITS-1:0] hex_q, hex_d;

    logic [W-1:0] ext, sext;

    // arm: a key must be seen released after reset before it may generate a press.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        press = '0;
        arm_d = arm_q | ({2{vld_q[1]}} & key_s2_q);
        for (int i = 0; i < 2; i++) begin
            if (key_s2_q[i] == acc_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                acc_d[i] = key_s2_q[i];
                cnt_d[i] = '0;
                press[i] = ~key_s2_q[i] & arm_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        mode_d   = press[0] ? mode_e'(mode_q + 2'd1) : mode_q;
        frozen_d = press[1] ? ~frozen_q : frozen_q;
        val_d    = frozen_q ? val_q : SW;
    end

    assign ext  = W'(val_q);
    assign sext = {{(W-IN_W){val_q[IN_W-1]}}, val_q};

    always_comb begin
        res_d  = ext;
        smag_d = 1'b0;
        neg_d  = 1'b0;
        unique case (mode_q)
            ModeRaw: res_d = ext;
            ModeC1:  res_d = ~ext;
            ModeC2:  res_d = ~ext + W'(1);
            ModeSmag: begin
                smag_d = 1'b1;
                neg_d  = val_q[IN_W-1];
                res_d  = val_q[IN_W-1] ? (W'(0) - sext) : ext;
            end
            default: res_d = ext;
        endcase
    end

    always_comb begin
        hex_d = '1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            hex_d[7*i +: 7] = glyph(res_q[4*i +: 4]);
        end
        if (smag_q) begin
            hex_d[7*(N_DIGITS-1) +: 7] = neg_q ? 7'b0111111 : 7'h7F;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_s1_q <= 2'b11;
            key_s2_q <= 2'b11;
            vld_q    <= 2'b00;
            acc_q    <= 2'b11;
            arm_q    <= 2'b00;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            mode_q   <= ModeRaw;
            frozen_q <= 1'b0;
            val_q    <= '0;
            res_q    <= '0;
            smag_q   <= 1'b0;
            neg_q    <= 1'b0;
            hex_q    <= '1;
        end else begin
            key_s1_q <= KEY;
            key_s2_q <= key_s1_q;
            vld_q    <= {vld_q[0], 1'b1};
            acc_q    <= acc_d;
            arm_q    <= arm_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            frozen_q <= frozen_d;
            val_q    <= val_d;
            res_q    <= res_d;
            smag_q   <= smag_d;
            neg_q    <= neg_d;
            hex_q    <= hex_d;
        end
    end

    assign HEX    = hex_q;
    assign MODE   = mode_q;
    assign FROZEN = frozen_q;

endmodule

// File: tb/tb_complement_display_ctrl.sv
// Bench for complement_display_ctrl: directed cases plus random keys/switches/resets
// checked every cycle against a behavioural display model.
module tb_complement_display_ctrl;

    localparam int unsigned IN_W = 10;
    localparam int unsigned ND   = 4;
    localparam int unsigned DB   = 4;
    localparam int unsigned W    = 4 * ND;
    localparam int unsigned HW   = 7 * ND;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [IN_W-1:0] sw;
    logic [1:0]      key;
    logic [HW-1:0]   hex;
    logic [1:0]      mode;
    logic            frozen;

    complement_display_ctrl #(
        .IN_W           (IN_W),
        .N_DIGITS       (ND),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .SW      (sw),
        .KEY     (key),
        .HEX     (hex),
        .MODE    (mode),
        .FROZEN  (frozen)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [6:0] char_glyph(input byte c);
        if (c >= 8'h30 && c <= 8'h39) return glyph_tab[c - 8'h30];
        if (c >= 8'h41 && c <= 8'h46) return glyph_tab[c - 8'h37];
        if (c == 8'h2D) return 7'h3F;
        return 7'h7F;
    endfunction

    // Leftmost character is the top digit.
    function automatic logic [HW-1:0] disp(input string s);
        logic [HW-1:0] r;
        for (int i = 0; i < int'(ND); i++) r[7*i +: 7] = char_glyph(s[ND-1-i]);
        return r;
    endfunction

    function automatic logic [HW-1:0] render(input int v, input int m);
        logic [HW-1:0] r;
        longint x;
        int sv;
        bit neg;
        neg = 1'b0;
        case (m)
            0: x = v;
            1: x = (1 << W) - 1 - v;
            2: x = ((1 << W) - v) % (1 << W);
            default: begin
                sv  = (v >= (1 << (IN_W - 1))) ? v - (1 << IN_W) : v;
                neg = (sv < 0);
                x   = neg ? -sv : sv;
            end
        endcase
        for (int i = 0; i < int'(ND); i++) r[7*i +: 7] = glyph_tab[int'((x >> (4 * i)) & 15)];
        if (m == 3) r[7*(ND-1) +: 7] = neg ? 7'h3F : 7'h7F;
        return r;
    endfunction

    // Behavioural model: keys seen 2 edges late, accepted after DB consecutive differing edges.
    int            m_val, m_mode, m_edges;
    bit            m_frozen;
    logic [HW-1:0] m_hex, m_pend;
    bit            kd1 [2], kd2 [2], acc [2], armed [2], ev [2];
    int            streak [2];
    bit            synced;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val = 0; m_mode = 0; m_frozen = 0; m_edges = 0;
            m_hex = '1;
            m_pend = render(0, 0);
            for (int k = 0; k < 2; k++) begin
                kd1[k] = 1; kd2[k] = 1; acc[k] = 1; armed[k] = 0; streak[k] = 0;
            end
        end else begin
            m_edges++;
            for (int k = 0; k < 2; k++) begin
                synced = kd2[k];
                ev[k] = 0;
                if (synced != acc[k]) begin
                    streak[k]++;
                    if (streak[k] == int'(DB)) begin
                        acc[k] = synced;
                        streak[k] = 0;
                        ev[k] = !synced && armed[k];
                    end
                end else begin
                    streak[k] = 0;
                end
                if (m_edges >= 3 && synced) armed[k] = 1;
                kd2[k] = kd1[k];
                kd1[k] = key[k];
            end
            m_hex  = m_pend;
            m_pend = render(m_val, m_mode);
            if (!m_frozen) m_val = int'(sw);
            if (ev[0]) m_mode = (m_mode + 1) % 4;
            if (ev[1]) m_frozen = !m_frozen;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_mode", 32'(mode), 32'(m_mode));
            check("model_frozen", 32'(frozen), 32'(m_frozen));
            check("model_hex", 32'(hex), 32'(m_hex));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k);
        key[k] = 1'b0;
        tick(10);
        key[k] = 1'b1;
        tick(10);
    endtask

    int run [2];

    initial begin
        rst_n = 1'b1;
        sw    = '0;
        key   = 2'b11;
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        #1;
        check("reset_hex", 32'(hex), 32'({HW{1'b1}}));
        check("reset_mode", 32'(mode), 32'd0);
        check("reset_frozen", 32'(frozen), 32'd0);
        tick(2);
        rst_n = 1'b1;

        sw = 10'h005;
        tick(4);
        check("t1_hex", 32'(hex), 32'(disp("0005")));
        check("t1_mode", 32'(mode), 32'd0);
        check("t1_frozen", 32'(frozen), 32'd0);

        press(0);
        check("t2_mode_c1", 32'(mode), 32'd1);
        check("t2_hex_c1", 32'(hex), 32'(disp("FFFA")));
        press(0);
        check("t2_mode_c2", 32'(mode), 32'd2);
        check("t2_hex_c2", 32'(hex), 32'(disp("FFFB")));

        press(0);
        check("t3_mode_smag", 32'(mode), 32'd3);
        sw = 10'h3FF; tick(4);
        check("t3_smag_m1", 32'(hex), 32'(disp("-001")));
        sw = 10'h200; tick(4);
        check("t3_smag_min", 32'(hex), 32'(disp("-200")));
        sw = 10'h1FF; tick(4);
        check("t3_smag_max", 32'(hex), 32'(disp(" 1FF")));
        sw = 10'h000; tick(4);
        check("t3_smag_zero", 32'(hex), 32'(disp(" 000")));

        press(0);
        check("t5_wrap", 32'(mode), 32'd0);
        sw = 10'h123; tick(4);
        press(1);
        check("t4_frozen", 32'(frozen), 32'd1);
        sw = 10'h3C0; tick(4);
        check("t4_hold", 32'(hex), 32'(disp("0123")));
        press(0);
        check("t4_c1_frozen", 32'(hex), 32'(disp("FEDC")));
        press(1);
        check("t4_unfrozen", 32'(frozen), 32'd0);
        check("t4_resample", 32'(hex), 32'(disp("FC3F")));

        repeat (3) begin
            key[0] = 1'b0; tick(2);
            key[0] = 1'b1; tick(2);
        end
        key[0] = 1'b0; tick(DB - 1);
        key[0] = 1'b1; tick(8);
        check("t5_bounce", 32'(mode), 32'd1);
        key[0] = 1'b0; tick(DB);
        key[0] = 1'b1; tick(8);
        check("t5_hold", 32'(mode), 32'd2);

        key[0] = 1'b0; tick(2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_hex", 32'(hex), 32'({HW{1'b1}}));
        check("t6_mode", 32'(mode), 32'd0);
        check("t6_frozen", 32'(frozen), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("t6_held_no_event", 32'(mode), 32'd0);
        key[0] = 1'b1; tick(10);
        press(0);
        check("t6_rearm", 32'(mode), 32'd1);

        run[0] = 0;
        run[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst_n = 1'b1;
            if ($urandom_range(0, 3) == 0) sw = IN_W'($urandom);
            for (int k = 0; k < 2; k++) begin
                if (run[k] == 0) begin
                    key[k] = ~key[k];
                    run[k] = $urandom_range(1, 9);
                end else begin
                    run[k]--;
                end
            end
            if ($urandom_range(0, 699) == 0) #2 rst_n = 1'b0;
        end
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
